iq_frame_packer: RTL and testbench

- Sits directly downstream of the quadrature DDC and consumes its decimated I/Q pairs (valid strobe plus 16-bit I and Q).
- Buffers the pairs in a synchronous FIFO and packs each pair into one 32-bit word.
- Emits fixed-length frames on a valid/ready stream toward the host DMA. Each frame is one header word followed by FRAME_LEN payload words.
- Counts and reports samples dropped on FIFO overflow.

---
 rtl/iq_stream_pkg.sv | 41 ++++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/iq_frame_packer.sv | 147 ++++++++++++++
 tb/tb_iq_frame_packer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/iq_stream_pkg.sv
// Shared definitions for the I/Q streaming path: sample and word widths,
// frame header field positions, frame FSM state encoding and the helpers
// that assemble payload and header words.
// No ports (package).
package iq_stream_pkg;

  localparam int IQ_W     = 16;
  localparam int WORD_W   = 32;

  // Header layout: sequence number in the upper half, drop count in the lower.
  localparam int SEQ_MSB  = 31;
  localparam int SEQ_LSB  = 16;
  localparam int DROP_MSB = 15;
  localparam int DROP_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } frame_state_e;

  // Payload word: I in the low half, Q in the high half.
  function automatic logic [WORD_W-1:0] pack_iq(input logic [IQ_W-1:0] i_s,
                                                input logic [IQ_W-1:0] q_s);
    logic [WORD_W-1:0] w;
    w = '0;
    w[IQ_W-1:0]      = i_s;
    w[WORD_W-1:IQ_W] = q_s;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] make_header(input logic [IQ_W-1:0] seq,
                                                    input logic [IQ_W-1:0] drops);
    logic [WORD_W-1:0] h;
    h = '0;
    h[SEQ_MSB:SEQ_LSB]   = seq;
    h[DROP_MSB:DROP_LSB] = drops;
    return h;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead (first-word-fall-through) FIFO.
// rd_data_o always presents the head word while the FIFO is not empty; a
// read strobe advances to the next word. Writes into a full FIFO and reads
// from an empty FIFO are ignored. full/empty/count all derive from the
// registered occupancy, so a same-cycle read never makes room for a write.
// Ports:
//   clk, reset      clock, synchronous active-high flush
//   wr_en_i/wr_data_i  write strobe and data
//   rd_en_i         pop head word
//   rd_data_o       head word
//   count_o         occupancy (0..2^DEPTH_LOG2)
//   full_o/empty_o  status flags
module sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  push;
  logic                  pop;

  assign full_o    = (count_q == DEPTH_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/iq_frame_packer.sv
// Packs decimated DDC I/Q pairs into 32-bit words, buffers them and emits
// fixed-length frames (one header word + FRAME_LEN payload words) on a
// valid/ready stream. The header carries a 16-bit frame sequence number and
// the number of samples dropped on overflow since the previous header.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            accept new samples when high
//   in_valid/in_i/in_q  DDC sample strobe and signed I/Q samples
//   m_valid/m_ready/m_data/m_last  output stream (registered)
//   overflow          sticky drop flag, cleared by clear_overflow
//   fill_level        current FIFO occupancy
module iq_frame_packer
  import iq_stream_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int FRAME_LEN  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                in_valid,
  input  logic [IQ_W-1:0]     in_i,
  input  logic [IQ_W-1:0]     in_q,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [WORD_W-1:0]   m_data,
  output logic                m_last,
  output logic                overflow,
  input  logic                clear_overflow,
  output logic [DEPTH_LOG2:0] fill_level
);

  localparam logic [DEPTH_LOG2:0]   FRAME_CNT = (DEPTH_LOG2 + 1)'(FRAME_LEN);
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX  = DEPTH_LOG2'(FRAME_LEN - 1);

  frame_state_e          state_q;
  logic [IQ_W-1:0]       frame_seq_q;
  logic [IQ_W-1:0]       drop_cnt_q;
  logic [IQ_W-1:0]       drop_cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  m_valid_q;
  logic                  m_last_q;
  logic [WORD_W-1:0]     m_data_q;
  logic                  overflow_q;

  logic                  wr_req;
  logic                  drop;
  logic                  fifo_pop;
  logic [WORD_W-1:0]     fifo_head;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign wr_req = in_valid && enable;
  assign drop   = wr_req && fifo_full;

  assign drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + 1'b1 : drop_cnt_q;

  // The head word is loaded into the output register on the header handshake
  // and on every non-final payload handshake, giving exactly FRAME_LEN pops.
  assign fifo_pop = m_ready && !fifo_empty &&
                    ((state_q == ST_HEADER) ||
                     ((state_q == ST_PAYLOAD) && !m_last_q));

  sync_fifo #(
    .DATA_W     (WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_req),
    .wr_data_i (pack_iq(in_i, in_q)),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      frame_seq_q <= '0;
      drop_cnt_q  <= '0;
      idx_q       <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      // A new drop takes priority over a coincident clear.
      if (drop)                overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;

      drop_cnt_q <= drop_cnt_d;

      case (state_q)
        ST_IDLE: begin
          // Only start once a whole frame is buffered so payload never stalls
          // on an empty FIFO.
          if (fifo_count >= FRAME_CNT) begin
            state_q    <= ST_HEADER;
            m_valid_q  <= 1'b1;
            m_last_q   <= 1'b0;
            m_data_q   <= make_header(frame_seq_q, drop_cnt_q);
            // A drop landing in the capture cycle belongs to the next frame.
            drop_cnt_q <= {{(IQ_W-1){1'b0}}, drop};
          end
        end
        ST_HEADER: begin
          if (m_ready) begin
            state_q     <= ST_PAYLOAD;
            frame_seq_q <= frame_seq_q + 1'b1;
            m_data_q    <= fifo_head;
            idx_q       <= '0;
            m_last_q    <= 1'b0;
          end
        end
        ST_PAYLOAD: begin
          if (m_ready) begin
            if (m_last_q) begin
              state_q   <= ST_IDLE;
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
            end else begin
              m_data_q  <= fifo_head;
              idx_q     <= idx_q + 1'b1;
              m_last_q  <= ((idx_q + 1'b1) == LAST_IDX);
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign m_data     = m_data_q;
  assign overflow   = overflow_q;
  assign fill_level = fifo_count;

endmodule

// File: tb/tb_iq_frame_packer.sv
module tb_iq_frame_packer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [15:0] in_i;
  logic [15:0] in_q;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        overflow;
  logic        clear_overflow;
  logic [3:0]  fill_level;

  int total = 0;
  int bad   = 0;

  iq_frame_packer #(
    .DEPTH_LOG2 (3),
    .FRAME_LEN  (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .in_valid       (in_valid),
    .in_i           (in_i),
    .in_q           (in_q),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .fill_level     (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] i_s, input logic [15:0] q_s);
    in_valid = 1'b1;
    in_i     = i_s;
    in_q     = q_s;
    tick();
    in_valid = 1'b0;
  endtask

  // One handshake cycle (m_ready assumed high), then check the newly shown word.
  task automatic expect_word(input string tag, input logic [31:0] exp, input logic last);
    tick();
    chk({tag, "_v"}, 32'(m_valid), 32'd1);
    chk(tag, m_data, exp);
    chk({tag, "_last"}, 32'(m_last), 32'(last));
  endtask

  task automatic wait_hdr(input string tag, input logic [31:0] exp);
    for (int c = 0; c < 16 && m_valid !== 1'b1; c++) tick();
    chk({tag, "_v"}, 32'(m_valid), 32'd1);
    chk(tag, m_data, exp);
    chk({tag, "_last"}, 32'(m_last), 32'd0);
  endtask

  task automatic chk_gap(input string tag);
    tick();
    chk(tag, 32'(m_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0;
    m_ready = 1'b1; clear_overflow = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    reset = 1'b0;

    // Basic frame: I=1..4, Q=-1..-4
    for (int k = 1; k <= 4; k++) push(16'(k), -16'(k));
    chk("b_fill", 32'(fill_level), 32'd4);
    chk("b_lat0", 32'(m_valid), 32'd0);
    tick();
    chk("b_hdr_v", 32'(m_valid), 32'd1);
    chk("b_hdr", m_data, 32'h0000_0000);
    chk("b_hdr_last", 32'(m_last), 32'd0);
    expect_word("b_w0", 32'hFFFF_0001, 1'b0);
    expect_word("b_w1", 32'hFFFE_0002, 1'b0);
    expect_word("b_w2", 32'hFFFD_0003, 1'b0);
    expect_word("b_w3", 32'hFFFC_0004, 1'b1);
    chk_gap("b_gap");
    chk("b_fill_end", 32'(fill_level), 32'd0);

    for (int k = 5; k <= 8; k++) push(16'(k), -16'(k));
    wait_hdr("b2_hdr", 32'h0001_0000);
    expect_word("b2_w0", 32'hFFFB_0005, 1'b0);
    expect_word("b2_w1", 32'hFFFA_0006, 1'b0);
    expect_word("b2_w2", 32'hFFF9_0007, 1'b0);
    expect_word("b2_w3", 32'hFFF8_0008, 1'b1);
    chk_gap("b2_gap");

    // Overflow: 11 pushes with no drain; clear on the last drop must lose
    m_ready = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      clear_overflow = (k == 11);
      push(16'(16'h10 + k), 16'(16'h20 + k));
    end
    clear_overflow = 1'b0;
    chk("o_fill", 32'(fill_level), 32'd8);
    chk("o_ovf_setwins", 32'(overflow), 32'd1);
    chk("o_hdr_pending", m_data, 32'h0002_0000);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("o_ovf_clr", 32'(overflow), 32'd0);
    m_ready = 1'b1;
    expect_word("o_w0", 32'h0021_0011, 1'b0);
    expect_word("o_w1", 32'h0022_0012, 1'b0);
    expect_word("o_w2", 32'h0023_0013, 1'b0);
    expect_word("o_w3", 32'h0024_0014, 1'b1);
    chk_gap("o_gap");
    wait_hdr("o_hdr_drop3", 32'h0003_0003);
    expect_word("o_w4", 32'h0025_0015, 1'b0);
    expect_word("o_w5", 32'h0026_0016, 1'b0);
    expect_word("o_w6", 32'h0027_0017, 1'b0);
    expect_word("o_w7", 32'h0028_0018, 1'b1);
    chk_gap("o_gap2");
    chk("o_fill_end", 32'(fill_level), 32'd0);

    // Simultaneous push/pop at 7, then push at full with concurrent pop
    m_ready = 1'b0;
    for (int k = 1; k <= 7; k++) push(16'(16'h100 + k), 16'(16'h200 + k));
    chk("s_fill7", 32'(fill_level), 32'd7);
    chk("s_hdr_drop0", m_data, 32'h0004_0000);
    m_ready = 1'b1;
    push(16'h0108, 16'h0208);
    chk("s_fill_same", 32'(fill_level), 32'd7);
    chk("s_w0", m_data, 32'h0201_0101);
    m_ready = 1'b0;
    push(16'h0109, 16'h0209);
    chk("s_fill8", 32'(fill_level), 32'd8);
    m_ready = 1'b1;
    push(16'h010A, 16'h020A);
    chk("s_fill_drop", 32'(fill_level), 32'd7);
    chk("s_w1", m_data, 32'h0202_0102);
    chk("s_ovf", 32'(overflow), 32'd1);
    expect_word("s_w2", 32'h0203_0103, 1'b0);
    expect_word("s_w3", 32'h0204_0104, 1'b1);
    chk_gap("s_gap");
    chk("s_fill5", 32'(fill_level), 32'd5);
    wait_hdr("s_hdr_drop1", 32'h0005_0001);
    expect_word("s2_w0", 32'h0205_0105, 1'b0);
    expect_word("s2_w1", 32'h0206_0106, 1'b0);
    expect_word("s2_w2", 32'h0207_0107, 1'b0);
    expect_word("s2_w3", 32'h0208_0108, 1'b1);
    chk_gap("s2_gap");
    chk("s_fill1", 32'(fill_level), 32'd1);

    // Reset in the middle of a payload
    for (int k = 11; k <= 13; k++) push(16'(16'h100 + k), 16'(16'h200 + k));
    wait_hdr("r_hdr", 32'h0006_0000);
    expect_word("r_w0", 32'h0209_0109, 1'b0);
    expect_word("r_w1", 32'h020B_010B, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r_valid", 32'(m_valid), 32'd0);
    chk("r_fill", 32'(fill_level), 32'd0);
    chk("r_last", 32'(m_last), 32'd0);
    chk("r_data", m_data, 32'd0);

    // Restarted sequence plus backpressure 1,0,0,1 in the payload
    for (int k = 1; k <= 4; k++) push(16'(16'h300 + k), 16'(16'h400 + k));
    wait_hdr("p_hdr_seq0", 32'h0000_0000);
    expect_word("p_w0", 32'h0401_0301, 1'b0);
    m_ready = 1'b0;
    tick();
    chk("p_hold1", m_data, 32'h0401_0301);
    chk("p_hold1_v", 32'(m_valid), 32'd1);
    tick();
    chk("p_hold2", m_data, 32'h0401_0301);
    chk("p_hold2_last", 32'(m_last), 32'd0);
    m_ready = 1'b1;
    expect_word("p_w1", 32'h0402_0302, 1'b0);
    expect_word("p_w2", 32'h0403_0303, 1'b0);
    expect_word("p_w3", 32'h0404_0304, 1'b1);
    chk_gap("p_gap");

    // enable=0: strobes ignored, no drops counted
    enable = 1'b0;
    for (int k = 0; k < 3; k++) push(16'h7777, 16'h7777);
    chk("e_fill", 32'(fill_level), 32'd0);
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) push(16'(16'h500 + k), 16'(16'h600 + k));
    wait_hdr("e_hdr", 32'h0001_0000);
    expect_word("e_w0", 32'h0601_0501, 1'b0);
    expect_word("e_w1", 32'h0602_0502, 1'b0);
    expect_word("e_w2", 32'h0603_0503, 1'b0);
    expect_word("e_w3", 32'h0604_0504, 1'b1);
    chk_gap("e_gap");

    // Sequence number wrap
    force dut.frame_seq_q = 16'hFFFF;
    tick();
    release dut.frame_seq_q;
    for (int k = 1; k <= 4; k++) push(16'(k), 16'(k));
    wait_hdr("w_hdr_ffff", 32'hFFFF_0000);
    for (int k = 1; k <= 4; k++) expect_word("w_w", {16'(k), 16'(k)}, (k == 4));
    chk_gap("w_gap");
    for (int k = 1; k <= 4; k++) push(16'(k), 16'(k));
    wait_hdr("w_hdr_wrap", 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
